accum5_seq: RTL and testbench

Sequential 5-bit accumulator that sits directly downstream of the 5-bit ripple adder. It holds the running sum in a register and feeds that sum back as the adder's in_a operand. Incoming operands drive in_b, and in_c is tied to 0. After a programmed number of operands it presents the batch sum and a sticky carry flag through a valid/ready output handshake.

---
 rtl/accum5_seq_if.sv | 23 ++
 rtl/accum5_seq.sv | 108 ++++++++++
 tb/tb_accum5_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum5_seq_if.sv
// rtl/accum5_seq_if.sv - operand/result handshake bundle for accum5_seq
interface accum5_seq_if;
  logic       start;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;
  logic       out_carry;
  logic       busy;

  // master drives operands and consumes results; slave is the accumulator
  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
  );
endinterface

// File: rtl/accum5_seq.sv
// rtl/accum5_seq.sv - batch accumulator around the 5-bit ripple adder
// The running sum feeds the adder's in_a; incoming operands feed in_b.
module adder5_ripple (
  input  logic [4:0] in_a,
  input  logic [4:0] in_b,
  input  logic       in_c,
  output logic [4:0] out_s,
  output logic       out_c
);
  logic [5:0] carry;

  assign carry[0] = in_c;

  for (genvar i = 0; i < 5; i++) begin : g_bit
    assign out_s[i]   = in_a[i] ^ in_b[i] ^ carry[i];
    assign carry[i+1] = (in_a[i] & in_b[i]) | (carry[i] & (in_a[i] ^ in_b[i]));
  end

  assign out_c = carry[5];
endmodule

module accum5_seq #(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 4
) (
  input logic        clk,
  input logic        reset_n,
  accum5_seq_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [4:0]       acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [4:0]       add_s;
  logic             add_c;

  adder5_ripple u_adder (
    .in_a  (acc_q),
    .in_b  (bus.in_data),
    .in_c  (1'b0),
    .out_s (add_s),
    .out_c (add_c)
  );

  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_d   = add_s;
          carry_d = carry_q | add_c;
          count_d = count_inc;
          // the final accept moves straight to DONE so out_valid rises on this edge
          if (count_inc == CNT_W'(NUM_OPS)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  // result registers double as the output holding stage until the next start
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = carry_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_accum5_seq.sv
// tb/tb_accum5_seq.sv - self-checking bench for accum5_seq (NUM_OPS=4 and NUM_OPS=1 builds)
module tb_accum5_seq;
  logic clk = 1'b0;
  logic reset_n;

  accum5_seq_if bus4 ();
  accum5_seq_if bus1 ();

  accum5_seq #(.NUM_OPS(4), .CNT_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  accum5_seq #(.NUM_OPS(1), .CNT_W(4)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // model: phase per DUT plus the list of operands accepted in the current batch
  localparam int M_IDLE = 0, M_ACCUM = 1, M_DONE = 2;
  int mode[2];
  int nops[2];
  int ops[2][16];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  function automatic int exp_sum(input int k);
    int s = 0;
    for (int i = 0; i < nops[k]; i++) s = (s + ops[k][i]) % 32;
    return s;
  endfunction

  function automatic int exp_carry(input int k);
    int s = 0;
    int c = 0;
    for (int i = 0; i < nops[k]; i++) begin
      if (s + ops[k][i] > 31) c = 1;
      s = (s + ops[k][i]) % 32;
    end
    return c;
  endfunction

  task automatic model_step(input int k, input logic st, input logic iv, input logic [4:0] d,
                            input logic ordy, input int n);
    if (!reset_n) begin
      mode[k] = M_IDLE;
      nops[k] = 0;
    end else if (mode[k] == M_IDLE) begin
      if (st) begin
        mode[k] = M_ACCUM;
        nops[k] = 0;
      end
    end else if (mode[k] == M_ACCUM) begin
      if (iv) begin
        ops[k][nops[k]] = int'(d);
        nops[k]++;
        if (nops[k] == n) mode[k] = M_DONE;
      end
    end else if (ordy) begin
      mode[k] = M_IDLE;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE;
      nops[k] = 0;
    end
  end

  always @(posedge clk) begin
    model_step(0, bus4.start, bus4.in_valid, bus4.in_data, bus4.out_ready, 4);
    model_step(1, bus1.start, bus1.in_valid, bus1.in_data, bus1.out_ready, 1);
  end

  task automatic cmp_dut(input int k, input logic ir, input logic ov, input logic [4:0] os,
                         input logic oc, input logic bz);
    check("in_ready", k, ir, mode[k] == M_ACCUM);
    check("out_valid", k, ov, mode[k] == M_DONE);
    check("busy", k, bz, mode[k] != M_IDLE);
    if (mode[k] != M_ACCUM) begin
      check("out_sum", k, os, exp_sum(k));
      check("out_carry", k, oc, exp_carry(k));
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut(0, bus4.in_ready, bus4.out_valid, bus4.out_sum, bus4.out_carry, bus4.busy);
      cmp_dut(1, bus1.in_ready, bus1.out_valid, bus1.out_sum, bus1.out_carry, bus1.busy);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start4();
    bus4.start = 1'b1;
    cyc();
    bus4.start = 1'b0;
  endtask

  task automatic feed4(input int v);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 5'(v);
    cyc();
    bus4.in_valid = 1'b0;
  endtask

  task automatic start1();
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
  endtask

  task automatic feed1(input int v);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 5'(v);
    cyc();
    bus1.in_valid = 1'b0;
  endtask

  // hand-computed result pinned against both the DUT and the model
  task automatic expect_result(input int k, input int s, input int c);
    check("lit_out_valid", k, (k == 0) ? bus4.out_valid : bus1.out_valid, 1);
    check("lit_out_sum", k, (k == 0) ? bus4.out_sum : bus1.out_sum, s);
    check("lit_out_carry", k, (k == 0) ? bus4.out_carry : bus1.out_carry, c);
    check("model_sum", k, exp_sum(k), s);
    check("model_carry", k, exp_carry(k), c);
  endtask

  task automatic batch4(input int a, input int b, input int c, input int d, input int s, input int cy);
    start4();
    feed4(a);
    feed4(b);
    feed4(c);
    check("pre_done_valid", 0, bus4.out_valid, 0);
    feed4(d);
    expect_result(0, s, cy);
    cyc();
    check("post_hs_valid", 0, bus4.out_valid, 0);
    check("post_hs_busy", 0, bus4.busy, 0);
    check("post_hs_sum_hold", 0, bus4.out_sum, s);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus4.start     = 1'b0; bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus1.start     = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    cyc();
    cyc();
    cmp_en  = 1'b1;
    reset_n = 1'b1;
    check("rst_out_valid", 0, bus4.out_valid, 0);
    check("rst_out_sum", 0, bus4.out_sum, 0);
    check("rst_in_ready", 0, bus4.in_ready, 0);
    check("rst_busy", 0, bus4.busy, 0);

    // operands offered while idle are ignored
    bus4.in_valid = 1'b1; bus4.in_data = 5'd7;
    cyc();
    bus4.in_valid = 1'b0;
    check("idle_ignore_busy", 0, bus4.busy, 0);

    bus4.out_ready = 1'b1;
    batch4(1, 2, 3, 4, 10, 0);
    batch4(31, 1, 0, 0, 0, 1);
    batch4(16, 16, 16, 16, 0, 1);

    // bubbles then backpressure, with a start pulse during DONE
    bus4.out_ready = 1'b0;
    start4();
    begin
      automatic bit v[7] = '{1, 0, 0, 1, 0, 1, 1};
      automatic int d[4] = '{5, 7, 9, 2};
      automatic int j = 0;
      for (int i = 0; i < 7; i++) begin
        bus4.in_valid = v[i];
        bus4.in_data  = v[i] ? 5'(d[j]) : 5'd31;
        if (v[i]) j++;
        cyc();
      end
      bus4.in_valid = 1'b0;
    end
    expect_result(0, 23, 0);
    for (int i = 0; i < 10; i++) begin
      bus4.start = (i == 4);
      cyc();
      check("bp_valid", 0, bus4.out_valid, 1);
      check("bp_sum", 0, bus4.out_sum, 23);
      check("bp_carry", 0, bus4.out_carry, 0);
      check("bp_in_ready", 0, bus4.in_ready, 0);
    end
    bus4.start     = 1'b0;
    bus4.out_ready = 1'b1;
    cyc();
    check("bp_release_valid", 0, bus4.out_valid, 0);
    check("bp_release_busy", 0, bus4.busy, 0);

    // start in ACCUM must not clear the partial batch
    start4();
    feed4(3);
    feed4(3);
    bus4.start = 1'b1;
    cyc();
    bus4.start = 1'b0;
    feed4(4);
    feed4(4);
    expect_result(0, 14, 0);
    cyc();

    // reset mid-batch discards the partial result
    start4();
    feed4(30);
    feed4(5);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    check("mid_rst_sum", 0, bus4.out_sum, 0);
    check("mid_rst_carry", 0, bus4.out_carry, 0);
    check("mid_rst_busy", 0, bus4.busy, 0);
    check("mid_rst_in_ready", 0, bus4.in_ready, 0);
    check("mid_rst_valid", 0, bus4.out_valid, 0);
    batch4(1, 1, 1, 1, 4, 0);

    // single-operand build, back-to-back batches
    bus1.out_ready = 1'b1;
    start1();
    feed1(9);
    expect_result(1, 9, 0);
    cyc();
    check("n1_hs_valid", 1, bus1.out_valid, 0);
    start1();
    feed1(5);
    expect_result(1, 5, 0);
    cyc();
    start1();
    feed1(30);
    expect_result(1, 30, 0);
    cyc();
    check("n1_end_busy", 1, bus1.busy, 0);

    cyc();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
